// File: rtl/mem_if_pkg.sv
// mem_if_pkg: shared types and default widths for the L2 <-> memory block interface
package mem_if_pkg;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ADDR_WIDTH = 32;
    localparam int DEF_BLOCK_SIZE = 16;
    localparam int DEF_MEM_BLOCKS = 256;
    localparam int DEF_LATENCY    = 4;
    typedef logic [DEF_BLOCK_SIZE-1:0][DEF_DATA_WIDTH-1:0] block_t;
    typedef enum logic [1:0] {IDLE, WAIT, RESPOND} state_t;
endpackage

// File: rtl/mem_block_array.sv
// mem_block_array: block storage with synchronous write and registered read
module mem_block_array #(
    parameter int W  = 512,
    parameter int N  = 256,
    parameter int IW = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [IW-1:0] widx,
    input  logic [W-1:0]  wdata,
    input  logic          re,
    input  logic [IW-1:0] ridx,
    output logic [W-1:0]  rdata
);
    logic [W-1:0] mem [N];
    always_ff @(posedge clk) begin
        if (we) mem[widx] <= wdata;
        if (re) rdata <= mem[ridx];
    end
endmodule

// File: rtl/mem_block_responder.sv
// mem_block_responder: backing memory answering L2 block reads/writes with a one-cycle ready after LATENCY cycles
module mem_block_responder
    import mem_if_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int BLOCK_SIZE = DEF_BLOCK_SIZE,
    parameter int MEM_BLOCKS = DEF_MEM_BLOCKS,
    parameter int LATENCY    = DEF_LATENCY
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [ADDR_WIDTH-1:0]                mem_addr,
    input  logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] mem_data_out,
    input  logic                                 mem_read,
    input  logic                                 mem_write,
    output logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] mem_data_block,
    output logic                                 mem_ready,
    output logic                                 busy
);
    localparam int OFFSET_WIDTH = $clog2(BLOCK_SIZE);
    localparam int BIDX_WIDTH   = $clog2(MEM_BLOCKS);
    localparam int CW           = LATENCY < 1 ? 1 : $clog2(LATENCY + 1);
    typedef logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] blk_t;

    state_t                state, state_n;
    logic [CW-1:0]         cnt;
    logic [BIDX_WIDTH-1:0] idx_q, idx;
    blk_t                  data_q, wdata, rdata;
    logic                  wr_q, is_wr, go, req, unused_addr;

    assign req         = mem_read | mem_write;
    assign unused_addr = ^mem_addr;
    // The commit/read happens on the edge entering RESPOND, which for LATENCY=0 is the acceptance edge
    assign idx   = state == IDLE ? mem_addr[OFFSET_WIDTH+BIDX_WIDTH-1:OFFSET_WIDTH] : idx_q;
    assign wdata = state == IDLE ? mem_data_out : data_q;
    assign is_wr = state == IDLE ? mem_write : wr_q;

    always_comb begin
        state_n = state;
        go      = 1'b0;
        case (state)
            IDLE: if (req) begin
                state_n = LATENCY == 0 ? RESPOND : WAIT;
                go      = LATENCY == 0;
            end
            WAIT: if (cnt == CW'(1)) begin
                state_n = RESPOND;
                go      = 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            idx_q  <= '0;
            data_q <= '0;
            wr_q   <= 1'b0;
        end else begin
            state <= state_n;
            if (state == IDLE && req) begin
                idx_q  <= idx;
                data_q <= mem_data_out;
                wr_q   <= mem_write;
                cnt    <= CW'(LATENCY);
            end else if (state == WAIT) cnt <= cnt - CW'(1);
        end
    end

    mem_block_array #(.W(BLOCK_SIZE*DATA_WIDTH), .N(MEM_BLOCKS), .IW(BIDX_WIDTH)) u_array (
        .clk  (clk),
        .we   (go & is_wr & ~rst),
        .widx (idx),
        .wdata(wdata),
        .re   (go & ~is_wr & ~rst),
        .ridx (idx),
        .rdata(rdata)
    );

    assign mem_ready      = state == RESPOND;
    assign busy           = state != IDLE;
    assign mem_data_block = mem_ready ? (wr_q ? data_q : rdata) : '0;
endmodule

// File: tb/tb_mem_block_responder.sv
// tb_mem_block_responder: table, directed and random checks of LATENCY=4 and LATENCY=0 responders
module tb_mem_block_responder;
    import mem_if_pkg::*;

    logic        clk = 0, rst = 1;
    logic        rd_i [2], wr_i [2], rdy_o [2], busy_o [2];
    logic [31:0] addr_i [2];
    block_t      dout_i [2], blk_o [2];
    int          total = 0, bad = 0;
    logic [511:0] mdl [2][256];
    bit          known [2][256];

    always #5 clk = ~clk;

    mem_block_responder #(.LATENCY(4)) u_l4 (
        .clk(clk), .rst(rst), .mem_addr(addr_i[0]), .mem_data_out(dout_i[0]),
        .mem_read(rd_i[0]), .mem_write(wr_i[0]), .mem_data_block(blk_o[0]),
        .mem_ready(rdy_o[0]), .busy(busy_o[0]));

    mem_block_responder #(.LATENCY(0)) u_l0 (
        .clk(clk), .rst(rst), .mem_addr(addr_i[1]), .mem_data_out(dout_i[1]),
        .mem_read(rd_i[1]), .mem_write(wr_i[1]), .mem_data_block(blk_o[1]),
        .mem_ready(rdy_o[1]), .busy(busy_o[1]));

    typedef struct {
        bit          rd;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] base;
        logic [31:0] exp;
    } vec_t;

    function automatic block_t mk(input logic [31:0] base);
        block_t b;
        for (int i = 0; i < 16; i++) b[i] = base + 32'(i);
        return b;
    endfunction

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic xact(input int s, input bit rd, input bit wr, input logic [31:0] a,
                        input block_t d, input block_t exp, input string nm);
        int k, lat;
        lat = s == 0 ? 4 : 0;
        rd_i[s] = rd; wr_i[s] = wr; addr_i[s] = a; dout_i[s] = d;
        tick();
        rd_i[s] = 0; wr_i[s] = 0; addr_i[s] = 0; dout_i[s] = mk($urandom);
        k = 1;
        chk({nm, ".busy"}, 512'(busy_o[s]), 512'd1);
        while (!rdy_o[s] && k < 40) begin
            tick();
            k++;
        end
        chk({nm, ".lat"}, 512'(k), 512'(lat + 1));
        chk({nm, ".data"}, blk_o[s], exp);
        tick();
        chk({nm, ".after"}, {blk_o[s], rdy_o[s], busy_o[s]}, 512'd0);
        if (wr) begin
            mdl[s][a[11:4]] = d;
            known[s][a[11:4]] = 1;
        end
    endtask

    initial begin
        vec_t v [10];
        int   n;
        for (int s = 0; s < 2; s++) begin
            rd_i[s] = 0; wr_i[s] = 0; addr_i[s] = 0; dout_i[s] = '0;
        end
        v[0] = '{0, 1, 32'h0000_0000, 32'h5000_0000, 32'h5000_0000};
        v[1] = '{0, 1, 32'h0000_0040, 32'hA000_0000, 32'hA000_0000};
        v[2] = '{1, 0, 32'h0000_0040, 32'h0,         32'hA000_0000};
        v[3] = '{1, 0, 32'h0000_0000, 32'h0,         32'h5000_0000};
        v[4] = '{0, 1, 32'h0000_1040, 32'hB000_0000, 32'hB000_0000};
        v[5] = '{1, 0, 32'h0000_0040, 32'h0,         32'hB000_0000};
        v[6] = '{1, 0, 32'h0000_0047, 32'h0,         32'hB000_0000};
        v[7] = '{0, 1, 32'h0000_0070, 32'hC000_0000, 32'hC000_0000};
        v[8] = '{1, 1, 32'h0000_0080, 32'hD000_0000, 32'hD000_0000};
        v[9] = '{1, 0, 32'hFFF0_0080, 32'h0,         32'hD000_0000};

        tick(); tick();
        rst = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("idle%0d", i), {blk_o[0], rdy_o[0], busy_o[0], blk_o[1], rdy_o[1], busy_o[1]}, 512'd0);
        end

        for (int i = 0; i < 10; i++)
            xact(0, v[i].rd, v[i].wr, v[i].addr, mk(v[i].base), mk(v[i].exp), $sformatf("vec%0d", i));

        // Reset during WAIT of a write to index 7 must abort it and leave the old block
        rd_i[0] = 0; wr_i[0] = 1; addr_i[0] = 32'h70; dout_i[0] = mk(32'hE000_0000);
        tick();
        wr_i[0] = 0; addr_i[0] = 0;
        tick();
        chk("abort.busy", 512'(busy_o[0]), 512'd1);
        rst = 1;
        tick();
        rst = 0;
        chk("abort.idle", {blk_o[0], rdy_o[0], busy_o[0]}, 512'd0);
        n = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            n += int'(rdy_o[0]);
        end
        chk("abort.noready", 512'(n), 512'd0);
        xact(0, 1, 0, 32'h70, '0, mk(32'hC000_0000), "abort.old");

        xact(1, 1, 1, 32'h40, mk(32'hF000_0000), mk(32'hF000_0000), "l0.both");
        xact(1, 1, 0, 32'h40, '0, mk(32'hF000_0000), "l0.rd");
        xact(1, 0, 1, 32'h200, mk(32'h1234_0000), mk(32'h1234_0000), "l0.wr");
        rd_i[1] = 1; addr_i[1] = 32'h200;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("held%0d.rdy", i), 512'(rdy_o[1]), 512'(i % 2 == 0));
            chk($sformatf("held%0d.data", i), blk_o[1], i % 2 == 0 ? mk(32'h1234_0000) : '0);
        end
        rd_i[1] = 0; addr_i[1] = 0;
        tick();
        chk("held.end", {blk_o[1], rdy_o[1], busy_o[1]}, 512'd0);

        for (int s = 0; s < 2; s++)
            for (int i = 0; i < 30; i++) begin
                logic [31:0] a;
                int          op;
                block_t      d, e;
                a  = $urandom;
                op = $urandom_range(0, 2);
                if (op == 0 && !known[s][a[11:4]]) op = 1;
                for (int j = 0; j < 16; j++) d[j] = $urandom;
                e = op == 0 ? mdl[s][a[11:4]] : d;
                xact(s, op != 1, op != 0, a, d, e, $sformatf("rnd%0d_%0d", s, i));
            end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_block_responder.md
Name: mem_block_responder

Overview:
- Backing-memory model and controller at the far end of the L2 memory interface. It is the responder to the L2 cache's block read/write requests.
- Stores whole cache blocks in an internal array and answers each request with a single-cycle mem_ready pulse after a programmable latency.
- Signal names match the L2 side so the two blocks connect port-to-port in the system top and benches.

Parameters:
- DATA_WIDTH, 32, bits per word
- ADDR_WIDTH, 32, byte/word address width of mem_addr
- BLOCK_SIZE, 16, words per block; OFFSET_WIDTH = $clog2(BLOCK_SIZE)
- MEM_BLOCKS, 256, blocks stored (power of 2); BIDX_WIDTH = $clog2(MEM_BLOCKS)
- LATENCY, 4, wait cycles between acceptance and response (0 allowed)

Ports:
- clk  in  1  clock
- rst  in  1  reset
- mem_addr  in  ADDR_WIDTH  request address; valid only in the request cycle
- mem_data_out  in  BLOCK_SIZE x DATA_WIDTH (packed)  write block from L2
- mem_read  in  1  block read request
- mem_write  in  1  block write request
- mem_data_block  out  BLOCK_SIZE x DATA_WIDTH (packed)  response block
- mem_ready  out  1  one-cycle response strobe
- busy  out  1  request in flight (WAIT or RESPOND)
- Interface decision: one clock clk; reset rst is synchronous and active-high.

Behaviour:
- Reset: at posedge clk with rst=1, the state becomes IDLE and the following outputs are set to 0: mem_ready, mem_data_block, busy, the latency counter, the captured addr/data/op.
- Reset does not clear the array contents.
- FSM states: IDLE, WAIT, RESPOND.
- IDLE: at a posedge with mem_read|mem_write=1, accept the request:
  - capture the block index mem_addr[OFFSET_WIDTH+BIDX_WIDTH-1:OFFSET_WIDTH], mem_data_out and the op;
  - load the counter with LATENCY;
  - go to WAIT, or go directly to RESPOND if LATENCY=0.
- Address handling: offset bits are ignored. Upper address bits above the index are ignored, so addresses alias modulo MEM_BLOCKS.
- The address is captured only at acceptance. The L2 drives mem_addr=0 while waiting, so inputs are ignored outside IDLE.
- WAIT: the counter decrements each cycle. When it reaches 1, go to RESPOND.
- Response timing: acceptance edge T gives mem_ready=1 during cycle T+LATENCY+1, for exactly one cycle.
- Entering RESPOND on a read:
  - mem_data_block <= array[idx].
- Entering RESPOND on a write:
  - array[idx] <= captured data;
  - mem_data_block <= captured data, so the L2 installs exactly what was written.
- mem_read and mem_write both high at acceptance: treated as a write. The response returns the written data.
- RESPOND: mem_ready=1, then unconditionally go to IDLE. mem_data_block returns to 0 on that exit edge.
- A request is never accepted in the RESPOND cycle, so there is a minimum of 1 idle cycle between the ready pulse and the next acceptance.
- A request held continuously high is re-accepted in the first IDLE cycle. The L2 drops its request on the ready cycle, so this does not occur in-system.
- busy = (state != IDLE).
- Reset mid-operation: the request is aborted. A write not yet committed (still in WAIT) is lost. No mem_ready is emitted.
- Array: single port, one write per cycle. Reads and writes never coincide because there is one op per transaction.

Decomposition:
- Package mem_if_pkg holds:
  - the state enum (IDLE/WAIT/RESPOND);
  - the block_t typedef (packed BLOCK_SIZE x DATA_WIDTH), shared with the L2 cache;
  - default width constants.
- Sub-module mem_block_array: synchronous-write / registered-read block storage, MEM_BLOCKS x block_t, with ports we, widx, wdata, re, ridx, rdata.
- The FSM, counter and capture registers stay in the top.

Test Plan:
- Reset, then idle 5 cycles -> mem_ready=0, busy=0, mem_data_block=0 throughout.
- Write to 0x0000_0040 (index 4) with data word[i]=0xA000_0000+i, LATENCY=4, request accepted at T -> mem_ready high only at T+5 with the same block; the next read of 0x0000_0040 returns it at T'+5.
- Read 0x0000_0040 while mem_addr is forced to 0 during WAIT -> index 4 data returned, not block 0.
- Aliasing with MEM_BLOCKS=256: write to 0x0000_1040 -> a read of 0x0000_0040 returns the new data. Offset bits 0x0000_0047 also map to index 4.
- Assert rst during WAIT of a write to index 7 -> no mem_ready; a later read of index 7 returns the old contents. Returning to IDLE takes one cycle.
- LATENCY=0 build; mem_read and mem_write both high -> treated as a write, mem_ready at T+1 with the write data. A request held high is re-accepted at T+2 with ready at T+3.
- Back-to-back in the system with L2_cache: a read miss fills and a subsequent L1 read hits with matching data.
